// File: rtl/lcd_pkg.sv
// Shared opcodes, FSM encodings and DDRAM address helpers for the LCD responder.
package lcd_pkg;

    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FSET  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    typedef logic [1:0] lcd_state_t;
    localparam lcd_state_t CLR_FILL = 2'd0;
    localparam lcd_state_t IDLE     = 2'd1;
    localparam lcd_state_t BUSY     = 2'd2;

    localparam logic [6:0] L1_LAST  = 7'h27;
    localparam logic [6:0] L2_FIRST = 7'h40;
    localparam logic [6:0] L2_LAST  = 7'h67;
    localparam logic [6:0] ONE_LAST = 7'h4F;
    localparam logic [6:0] LINE_LEN = 7'd40;

    localparam logic [7:0] BLANK       = 8'h20;
    localparam int         DDRAM_DEPTH = 80;

    // Line 2 occupies linear cells 40..79 in two-line mode.
    function automatic logic [6:0] lin_idx(input logic [6:0] a, input logic two_line);
        if (two_line && (a >= L2_FIRST)) return a - L2_FIRST + LINE_LEN;
        return a;
    endfunction

    function automatic logic ac_legal(input logic [6:0] a, input logic two_line);
        if (two_line) return (a <= L1_LAST) || ((a >= L2_FIRST) && (a <= L2_LAST));
        return a <= ONE_LAST;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                           input logic two_line);
        logic [6:0] r;
        if (up) begin
            if (two_line && (a == L1_LAST))       r = L2_FIRST;
            else if (two_line && (a == L2_LAST))  r = 7'h00;
            else if (!two_line && (a == ONE_LAST)) r = 7'h00;
            else                                  r = a + 7'd1;
        end else begin
            if (a == 7'h00)                       r = two_line ? L2_LAST : ONE_LAST;
            else if (two_line && (a == L2_FIRST)) r = L1_LAST;
            else                                  r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic up);
        if (up) return (o >= 6'd39) ? 6'd0 : o + 6'd1;
        return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

endpackage

// File: rtl/lcd_char_responder_e_sync.sv
// Brings the controller's E strobe into clk and flags its edges.
module lcd_char_responder_e_sync (
    input  logic clk,
    input  logic rst,
    input  logic e_i,
    output logic e_level_o,
    output logic e_rise_o,
    output logic e_fall_o
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= e_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign e_level_o = sync_q;
    assign e_rise_o  = sync_q & ~prev_q;
    assign e_fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/lcd_char_responder.sv
// HD44780-style 2x40 character LCD responder: executes bus transactions and exposes DDRAM/state.
//   state    | meaning
//   CLR_FILL | writing BLANK to linear cells 0..CLR_DEPTH-1, one per cycle
//   IDLE     | ready; write edges are decoded and executed
//   BUSY     | down-counting the post-command busy time
module lcd_char_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC  = 40,
    parameter int CLR_DEPTH = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_din,
    output logic [7:0] lcd_dout,
    output logic       lcd_doe,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic [5:0] shift_ofs,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       cmd_drop
);
    localparam int               CNT_W     = $clog2(BUSY_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BUSY_CYC - 1);
    localparam logic [6:0]       FILL_LAST = 7'(CLR_DEPTH - 1);

    logic             e_level, e_rise, e_fall;
    logic             rs_q, rw_q;
    logic [7:0]       din_q;
    lcd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       fill_q, fill_d;
    logic [6:0]       ac_q, ac_d;
    logic [5:0]       ofs_q, ofs_d;
    logic             id_q, id_d, s_q, s_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, tl_q, tl_d;
    logic             strobe_q, strobe_d, drop_q, drop_d;
    logic             doe_q;
    logic [7:0]       dout_q, dbg_q;
    logic [7:0]       mem_q [0:DDRAM_DEPTH-1];
    logic             mem_we;
    logic [6:0]       mem_idx, rd_idx;
    logic [7:0]       mem_wdata, rd_byte;

    lcd_char_responder_e_sync u_e_sync (
        .clk       (clk),
        .rst       (rst),
        .e_i       (lcd_e),
        .e_level_o (e_level),
        .e_rise_o  (e_rise),
        .e_fall_o  (e_fall)
    );

    // Bus fields are held from the last cycle synced E was high, so they are valid at the fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_q  <= 1'b0;
            rw_q  <= 1'b0;
            din_q <= 8'h00;
        end else if (e_level) begin
            rs_q  <= lcd_rs;
            rw_q  <= lcd_rw;
            din_q <= lcd_din;
        end
    end

    assign rd_idx  = lin_idx(ac_q, tl_q);
    assign rd_byte = (rd_idx < 7'(DDRAM_DEPTH)) ? mem_q[rd_idx] : 8'h00;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        ac_d      = ac_q;
        ofs_d     = ofs_q;
        id_d      = id_q;
        s_d       = s_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        tl_d      = tl_q;
        strobe_d  = 1'b0;
        drop_d    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = 7'd0;
        mem_wdata = 8'h00;

        case (state_q)
            CLR_FILL: begin
                mem_we    = 1'b1;
                mem_idx   = fill_q;
                mem_wdata = BLANK;
                if (fill_q == FILL_LAST) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    ac_d    = 7'd0;
                    ofs_d   = 6'd0;
                    id_d    = 1'b1;
                end else begin
                    fill_d = fill_q + 7'd1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase

        if (e_fall) begin
            if (rw_q && !rs_q) begin
                strobe_d = 1'b1;
            end else if (state_q != IDLE) begin
                drop_d = 1'b1;
            end else if (rw_q) begin
                strobe_d = 1'b1;
                ac_d     = ac_step(ac_q, id_q, tl_q);
            end else begin
                strobe_d = 1'b1;
                state_d  = BUSY;
                cnt_d    = CNT_LOAD;
                if (rs_q) begin
                    mem_we    = 1'b1;
                    mem_idx   = rd_idx;
                    mem_wdata = din_q;
                    ac_d      = ac_step(ac_q, id_q, tl_q);
                    if (s_q) ofs_d = ofs_step(ofs_q, id_q);
                end else if (|(din_q & OP_DDRAM)) begin
                    if (ac_legal(din_q[6:0], tl_q)) ac_d   = din_q[6:0];
                    else                            drop_d = 1'b1;
                end else if (|(din_q & OP_CGRAM)) begin
                    ac_d = ac_q;
                end else if (|(din_q & OP_FSET)) begin
                    tl_d = din_q[3];
                end else if (|(din_q & OP_SHIFT)) begin
                    if (din_q[3]) ofs_d = ofs_step(ofs_q, din_q[2]);
                    else          ac_d  = ac_step(ac_q, din_q[2], tl_q);
                end else if (|(din_q & OP_DISP)) begin
                    {disp_d, cur_d, blink_d} = din_q[2:0];
                end else if (|(din_q & OP_ENTRY)) begin
                    {id_d, s_d} = din_q[1:0];
                end else if (|(din_q & OP_HOME)) begin
                    ac_d  = 7'd0;
                    ofs_d = 6'd0;
                end else if (|(din_q & OP_CLR)) begin
                    state_d = CLR_FILL;
                    fill_d  = 7'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLR_FILL;
            cnt_q    <= '0;
            fill_q   <= 7'd0;
            ac_q     <= 7'd0;
            ofs_q    <= 6'd0;
            id_q     <= 1'b1;
            s_q      <= 1'b0;
            disp_q   <= 1'b0;
            cur_q    <= 1'b0;
            blink_q  <= 1'b0;
            tl_q     <= 1'b0;
            strobe_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            ac_q     <= ac_d;
            ofs_q    <= ofs_d;
            id_q     <= id_d;
            s_q      <= s_d;
            disp_q   <= disp_d;
            cur_q    <= cur_d;
            blink_q  <= blink_d;
            tl_q     <= tl_d;
            strobe_q <= strobe_d;
            drop_q   <= drop_d;
        end
    end

    // DDRAM has no reset; the power-on fill defines it.
    always_ff @(posedge clk) begin
        if (mem_we && (mem_idx < 7'(DDRAM_DEPTH))) mem_q[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_q  <= 8'h00;
            doe_q  <= 1'b0;
            dout_q <= 8'h00;
        end else begin
            dbg_q <= (dbg_addr < 7'(DDRAM_DEPTH)) ? mem_q[dbg_addr] : 8'h00;
            if (e_rise)      doe_q <= lcd_rw;
            else if (e_fall) doe_q <= 1'b0;
            if (e_level && lcd_rw) dout_q <= lcd_rs ? rd_byte : {busy, ac_q};
            else                   dout_q <= 8'h00;
        end
    end

    assign busy       = (state_q != IDLE);
    assign ac         = ac_q;
    assign shift_ofs  = ofs_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign two_line   = tl_q;
    assign cmd_strobe = strobe_q;
    assign cmd_drop   = drop_q;
    assign lcd_doe    = doe_q;
    assign lcd_dout   = dout_q;
    assign dbg_data   = dbg_q;

endmodule
